// File: rtl/axi_lite_cmd_master_pkg.sv
// axi_lite_pkg: shared types and response codes for the AXI4-Lite command master
package axi_lite_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

   typedef struct packed {
      logic        we;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic [15:0] latency;
   } rsp_t;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// axi4lite_intf: AXI4-Lite bus bundle with master and slave views
interface axi4lite_intf #(parameter int AWIDTH = 32);
   logic              awvalid, awready;
   logic [AWIDTH-1:0] awaddr;
   logic [2:0]        awprot;
   logic              wvalid, wready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              bvalid, bready;
   logic [1:0]        bresp;
   logic              arvalid, arready;
   logic [AWIDTH-1:0] araddr;
   logic [2:0]        arprot;
   logic              rvalid, rready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns a register-command stream into single AXI4-Lite transactions
module axi_lite_cmd_master
   import axi_lite_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int LATW   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_we,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic [LATW-1:0]   rsp_latency,
   axi4lite_intf.master      axi
);

   state_t            state, state_n;
   logic [AWIDTH-1:0] addr_q;
   logic              aw_done, w_done;
   logic [LATW-1:0]   lat;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

   // gating with rst_n keeps cmd_ready low while reset is held
   assign cmd_ready   = state == IDLE && rst_n;
   assign rsp_valid   = state == RSP;
   assign axi.awvalid = state == WR_REQ && !aw_done;
   assign axi.wvalid  = state == WR_REQ && !w_done;
   assign axi.bready  = state == WR_RESP;
   assign axi.arvalid = state == RD_REQ;
   assign axi.rready  = state == RD_RESP;
   assign axi.awaddr  = addr_q;
   assign axi.araddr  = addr_q;
   assign axi.awprot  = 3'b000;
   assign axi.arprot  = 3'b000;
   assign aw_hs = axi.awvalid && axi.awready;
   assign w_hs  = axi.wvalid && axi.wready;
   assign b_hs  = axi.bvalid && axi.bready;
   assign ar_hs = axi.arvalid && axi.arready;
   assign r_hs  = axi.rvalid && axi.rready;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;

   // next state: write waits for both AW and W, in either order
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_n = cmd_we ? WR_REQ : RD_REQ;
         WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
         WR_RESP: if (b_hs) state_n = RSP;
         RD_REQ:  if (ar_hs) state_n = RD_RESP;
         RD_RESP: if (r_hs) state_n = RSP;
         RSP:     if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // command latch, per-channel done flags, saturating latency and response capture
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         addr_q      <= '0;
         axi.wdata   <= '0;
         axi.wstrb   <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         lat         <= '0;
         rsp_we      <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= '0;
         rsp_latency <= '0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            addr_q    <= cmd_addr;
            axi.wdata <= cmd_wdata;
            axi.wstrb <= cmd_wstrb;
            rsp_we    <= cmd_we;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            lat       <= LATW'(1);
         end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (lat != '1) lat <= lat + LATW'(1);
         end
         if (b_hs) begin
            rsp_rdata   <= '0;
            rsp_resp    <= axi.bresp;
            rsp_latency <= lat;
         end
         if (r_hs) begin
            rsp_rdata   <= axi.rdata;
            rsp_resp    <= axi.rresp;
            rsp_latency <= lat;
         end
      end

endmodule
